// File: rtl/phase_monitor.sv
// -----------------------------------------------------------------------------
// phase_monitor
//
// Receive-side checker for one BLDC half-bridge phase. It samples the
// pwm_high / pwm_low gate-drive pair once per clock and measures every PWM
// cycle: period, high-side on-time and both dead-time gaps. It flags
// shoot-through and dead-time violations and reports static (non-switching)
// phase states after a timeout.
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   pwm_high       high-side gate signal (same clock domain)
//   pwm_low        low-side gate signal (same clock domain)
//   clear_faults   one-cycle pulse, clears the sticky fault flags
//   period         cycles between consecutive pwm_high rising edges
//   high_time      cycles pwm_high was asserted within that period
//   dead_hl        both-low gap from pwm_high fall to pwm_low rise (all-ones if none)
//   dead_lh        both-low gap from pwm_low fall to pwm_high rise (all-ones if none)
//   meas_valid     one-cycle pulse when the measurement outputs update
//   static_code    00 switching, 01 stuck low-side, 10 stuck high-side, 11 both off
//   shoot_through  sticky: both gates seen high in the same sample
//   dead_violation sticky: a recorded dead gap was shorter than MIN_DEAD
// -----------------------------------------------------------------------------
module phase_monitor #(
  parameter int CNT_WIDTH = 11,
  parameter int MIN_DEAD  = 2,
  parameter int TIMEOUT   = 2047
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 pwm_high,
  input  logic                 pwm_low,
  input  logic                 clear_faults,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic [CNT_WIDTH-1:0] dead_hl,
  output logic [CNT_WIDTH-1:0] dead_lh,
  output logic                 meas_valid,
  output logic [1:0]           static_code,
  output logic                 shoot_through,
  output logic                 dead_violation
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_DEAD_HL,
    S_LOW,
    S_DEAD_LH
  } state_t;

  state_t state_reg;

  // Registered input samples; sh_prev_reg is only used for rising-edge detect.
  logic sh_reg;
  logic sl_reg;
  logic sh_prev_reg;

  logic [CNT_WIDTH-1:0] period_cnt_reg;
  logic [CNT_WIDTH-1:0] high_cnt_reg;
  logic [CNT_WIDTH-1:0] gap_cnt_reg;
  logic [CNT_WIDTH-1:0] idle_cnt_reg;
  logic [CNT_WIDTH-1:0] dead_hl_rec_reg;
  logic [CNT_WIDTH-1:0] dead_lh_rec_reg;
  logic                 timed_out_reg;

  // ---------------------------------------------------------------------------
  // Decode of the registered samples
  // ---------------------------------------------------------------------------
  logic       sh_rise;
  logic       both_on;
  logic       timeout_hit;
  logic [1:0] idle_code;
  logic       hl_record;
  logic       lh_record;
  logic       boundary;
  logic       gap_record;
  logic       gap_short;
  logic [CNT_WIDTH-1:0] pub_dead_lh;

  assign sh_rise = sh_reg & ~sh_prev_reg;
  assign both_on = sh_reg & sl_reg;

  // A rising edge restarts the idle count, and a shoot-through sample is
  // handled on its own, so neither can coincide with a timeout publish.
  assign timeout_hit = (idle_cnt_reg == TIMEOUT_CNT) & ~sh_rise & ~both_on;

  // sl only -> 01, sh only -> 10, neither -> 11.
  assign idle_code = {~sl_reg, ~sh_reg};

  // Gap recording and period boundaries per state. Both signals were low in the
  // previous sample while in a DEAD_* state, so a level of 1 there is an edge.
  // When a gate hands over directly (fall and opposite rise in one sample) the
  // gap counter already reads zero, because the previous sample had a gate on,
  // so every record can simply take gap_cnt_reg.
  always_comb begin
    hl_record = 1'b0;
    lh_record = 1'b0;
    boundary  = 1'b0;
    if (!both_on && !timeout_hit) begin
      case (state_reg)
        S_HIGH: begin
          hl_record = ~sh_reg & sl_reg;
        end
        S_DEAD_HL: begin
          boundary  = sh_reg;
          hl_record = ~sh_reg & sl_reg;
        end
        S_LOW: begin
          boundary  = sh_reg & ~sl_reg;
          lh_record = sh_reg & ~sl_reg;
        end
        S_DEAD_LH: begin
          boundary  = sh_reg;
          lh_record = sh_reg;
        end
        default: begin
          hl_record = 1'b0;
        end
      endcase
    end
  end

  assign gap_record  = hl_record | lh_record;
  assign pub_dead_lh = lh_record ? gap_cnt_reg : dead_lh_rec_reg;

  // MIN_DEAD of zero turns the dead-time check off entirely.
  generate
    if (MIN_DEAD > 0) begin : g_dead_chk
      assign gap_short = (gap_cnt_reg < CNT_WIDTH'(MIN_DEAD));
    end else begin : g_no_dead_chk
      assign gap_short = 1'b0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sampling, counters, FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      sh_reg          <= 1'b0;
      sl_reg          <= 1'b0;
      sh_prev_reg     <= 1'b0;
      period_cnt_reg  <= '0;
      high_cnt_reg    <= '0;
      gap_cnt_reg     <= '0;
      idle_cnt_reg    <= '0;
      dead_hl_rec_reg <= '0;
      dead_lh_rec_reg <= '0;
      timed_out_reg   <= 1'b0;
      period          <= '0;
      high_time       <= '0;
      dead_hl         <= '0;
      dead_lh         <= '0;
      meas_valid      <= 1'b0;
      static_code     <= 2'b11;
      shoot_through   <= 1'b0;
      dead_violation  <= 1'b0;
    end else begin
      sh_reg      <= pwm_high;
      sl_reg      <= pwm_low;
      sh_prev_reg <= sh_reg;
      meas_valid  <= 1'b0;

      // Consecutive both-low samples, saturating.
      if (sh_reg || sl_reg) begin
        gap_cnt_reg <= '0;
      end else if (gap_cnt_reg != CNT_MAX) begin
        gap_cnt_reg <= gap_cnt_reg + CNT_ONE;
      end

      // The rising-edge sample itself counts as the first cycle of the new
      // period and of its high phase.
      if (sh_rise) begin
        period_cnt_reg <= CNT_ONE;
        high_cnt_reg   <= CNT_ONE;
        idle_cnt_reg   <= CNT_ONE;
        timed_out_reg  <= 1'b0;
      end else begin
        if (period_cnt_reg != CNT_MAX) begin
          period_cnt_reg <= period_cnt_reg + CNT_ONE;
        end
        if (sh_reg && (high_cnt_reg != CNT_MAX)) begin
          high_cnt_reg <= high_cnt_reg + CNT_ONE;
        end
        if (idle_cnt_reg != TIMEOUT_CNT) begin
          idle_cnt_reg <= idle_cnt_reg + CNT_ONE;
        end
      end

      // Sticky faults: a fresh violation beats a simultaneous clear.
      shoot_through  <= both_on | (shoot_through & ~clear_faults);
      dead_violation <= (gap_record & gap_short) | (dead_violation & ~clear_faults);

      if (both_on) begin
        // Measurement is untrustworthy; wait for two clean rises again.
        state_reg <= S_IDLE;
      end else if (timeout_hit) begin
        state_reg     <= S_IDLE;
        timed_out_reg <= 1'b1;
        // Repeat timeouts only report when the static level changes.
        if (!timed_out_reg || (idle_code != static_code)) begin
          period      <= '0;
          high_time   <= '0;
          dead_hl     <= CNT_MAX;
          dead_lh     <= CNT_MAX;
          meas_valid  <= 1'b1;
          static_code <= idle_code;
        end
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (sh_rise) begin
              state_reg       <= S_HIGH;
              dead_hl_rec_reg <= CNT_MAX;
              dead_lh_rec_reg <= CNT_MAX;
            end
          end
          S_HIGH: begin
            if (!sh_reg) begin
              state_reg <= sl_reg ? S_LOW : S_DEAD_HL;
            end
          end
          S_DEAD_HL: begin
            if (sh_reg) begin
              state_reg <= S_HIGH;
            end else if (sl_reg) begin
              state_reg <= S_LOW;
            end
          end
          S_LOW: begin
            if (!sl_reg) begin
              state_reg <= sh_reg ? S_HIGH : S_DEAD_LH;
            end
          end
          S_DEAD_LH: begin
            if (sh_reg) begin
              state_reg <= S_HIGH;
            end else if (sl_reg) begin
              state_reg <= S_LOW;
            end
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase

        if (hl_record) begin
          dead_hl_rec_reg <= gap_cnt_reg;
        end

        if (boundary) begin
          period          <= period_cnt_reg;
          high_time       <= high_cnt_reg;
          dead_hl         <= dead_hl_rec_reg;
          dead_lh         <= pub_dead_lh;
          meas_valid      <= 1'b1;
          static_code     <= 2'b00;
          dead_hl_rec_reg <= CNT_MAX;
          dead_lh_rec_reg <= CNT_MAX;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_monitor.sv
// -----------------------------------------------------------------------------
// tb_phase_monitor
//
// Directed bench for phase_monitor. Inputs change 1 time unit after a rising
// clock edge and outputs are read at the same point, so a sample driven before
// tick k is seen by the FSM at tick k+1 and published values are visible
// right after that tick.
// -----------------------------------------------------------------------------
module tb_phase_monitor;

  localparam int CW  = 11;
  localparam int TMO = 2047;
  localparam int ALL = (1 << CW) - 1;

  logic          clock        = 1'b0;
  logic          reset_n      = 1'b0;
  logic          pwm_high     = 1'b0;
  logic          pwm_low      = 1'b0;
  logic          clear_faults = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic [CW-1:0] dead_hl;
  logic [CW-1:0] dead_lh;
  logic          meas_valid;
  logic [1:0]    static_code;
  logic          shoot_through;
  logic          dead_violation;

  int   n_cmp    = 0;
  int   n_err    = 0;
  int   mv_count = 0;
  logic mv_at1;
  logic mv_at2;

  phase_monitor #(
    .CNT_WIDTH(CW),
    .MIN_DEAD (2),
    .TIMEOUT  (TMO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pwm_high      (pwm_high),
    .pwm_low       (pwm_low),
    .clear_faults  (clear_faults),
    .period        (period),
    .high_time     (high_time),
    .dead_hl       (dead_hl),
    .dead_lh       (dead_lh),
    .meas_valid    (meas_valid),
    .static_code   (static_code),
    .shoot_through (shoot_through),
    .dead_violation(dead_violation)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; every meas_valid pulse is counted here.
  task automatic tick();
    @(posedge clock);
    #1;
    if (meas_valid === 1'b1) mv_count++;
  endtask

  task automatic drive(input logic h, input logic l, input int n);
    pwm_high = h;
    pwm_low  = l;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One PWM cycle: high, dead, low, dead. meas_valid is captured on the first
  // two ticks after the rise to observe publish latency.
  task automatic pwm_cycle(input int per, input int hi, input int dhl, input int dlh);
    pwm_high = 1'b1;
    pwm_low  = 1'b0;
    tick();
    mv_at1 = meas_valid;
    tick();
    mv_at2 = meas_valid;
    drive(1'b1, 1'b0, hi - 2);
    drive(1'b0, 1'b0, dhl);
    drive(1'b0, 1'b1, per - hi - dhl - dlh);
    drive(1'b0, 1'b0, dlh);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    pwm_high     = 1'b0;
    pwm_low      = 1'b0;
    clear_faults = 1'b0;
    tick();
    tick();
    reset_n  = 1'b1;
    mv_count = 0;
  endtask

  initial begin
    // ---------------- reset state and normal switching ----------------
    do_reset();
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_dead_hl", dead_hl, 0);
    check("rst_dead_lh", dead_lh, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_static", static_code, 2'b11);
    check("rst_shoot", shoot_through, 0);
    check("rst_deadv", dead_violation, 0);

    pwm_cycle(100, 40, 3, 3);
    check("first_rise_nopub", mv_at2, 0);
    pwm_cycle(100, 40, 3, 3);
    pwm_cycle(100, 40, 3, 3);
    check("lat_n1", mv_at1, 0);
    check("lat_n2", mv_at2, 1);
    check("nom_count", mv_count, 2);
    check("nom_period", period, 100);
    check("nom_high", high_time, 40);
    check("nom_dead_hl", dead_hl, 3);
    check("nom_dead_lh", dead_lh, 3);
    check("nom_static", static_code, 2'b00);
    check("nom_shoot", shoot_through, 0);
    check("nom_deadv", dead_violation, 0);

    pwm_cycle(60, 15, 4, 2);
    pwm_cycle(60, 15, 4, 2);
    check("alt_count", mv_count, 4);
    check("alt_period", period, 60);
    check("alt_high", high_time, 15);
    check("alt_dead_hl", dead_hl, 4);
    check("alt_dead_lh", dead_lh, 2);

    // ---------------- short dead gaps and fault clearing ----------------
    do_reset();
    drive(1'b1, 1'b0, 40);
    drive(1'b0, 1'b0, 1);
    drive(1'b0, 1'b1, 50);
    check("dv_set_hl", dead_violation, 1);
    clear_faults = 1'b1;
    drive(1'b0, 1'b1, 1);
    clear_faults = 1'b0;
    check("dv_cleared", dead_violation, 0);
    drive(1'b0, 1'b1, 8);
    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 2);
    check("dv_set_lh", dead_violation, 1);
    check("dv_pub_valid", meas_valid, 1);
    check("dv_period", period, 101);
    check("dv_high", high_time, 40);
    check("dv_dead_hl", dead_hl, 1);
    check("dv_dead_lh", dead_lh, 1);
    drive(1'b1, 1'b0, 36);
    clear_faults = 1'b1;
    drive(1'b1, 1'b0, 1);
    clear_faults = 1'b0;
    check("dv_clear2", dead_violation, 0);
    drive(1'b0, 1'b0, 1);
    drive(1'b0, 1'b1, 1);
    clear_faults = 1'b1;
    drive(1'b0, 1'b1, 1);
    clear_faults = 1'b0;
    check("dv_set_wins", dead_violation, 1);

    // ---------------- shoot-through ----------------
    do_reset();
    pwm_cycle(100, 40, 3, 3);
    pwm_cycle(100, 40, 3, 3);
    drive(1'b1, 1'b0, 20);
    check("st_pre_count", mv_count, 2);
    drive(1'b1, 1'b1, 1);
    drive(1'b1, 1'b0, 19);
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 54);
    drive(1'b0, 1'b0, 3);
    check("st_flag", shoot_through, 1);
    check("st_nopub", mv_count, 2);
    pwm_cycle(100, 40, 3, 3);
    check("st_rearm_nopub", mv_count, 2);
    pwm_cycle(100, 40, 3, 3);
    check("st_resume_count", mv_count, 3);
    check("st_resume_period", period, 100);
    check("st_sticky", shoot_through, 1);
    clear_faults = 1'b1;
    tick();
    clear_faults = 1'b0;
    check("st_cleared", shoot_through, 0);

    // ---------------- duty 0: stuck low side ----------------
    do_reset();
    pwm_cycle(100, 40, 3, 3);
    pwm_cycle(100, 40, 3, 3);
    drive(1'b1, 1'b0, 40);
    drive(1'b0, 1'b0, 3);
    check("to_pre_count", mv_count, 2);
    drive(1'b0, 1'b1, 2005);
    check("to_not_early", mv_count, 2);
    drive(1'b0, 1'b1, 1);
    check("to_valid", meas_valid, 1);
    check("to_count", mv_count, 3);
    check("to_period", period, 0);
    check("to_high", high_time, 0);
    check("to_dead_hl", dead_hl, ALL);
    check("to_dead_lh", dead_lh, ALL);
    check("to_static", static_code, 2'b01);
    drive(1'b0, 1'b1, 100);
    check("to_no_repeat", mv_count, 3);
    drive(1'b0, 1'b0, 2);
    check("to_change_valid", meas_valid, 1);
    check("to_change_static", static_code, 2'b11);
    pwm_cycle(100, 40, 3, 3);
    check("to_rearm_nopub", mv_count, 4);
    pwm_cycle(100, 40, 3, 3);
    check("to_resume_count", mv_count, 5);
    check("to_resume_static", static_code, 2'b00);
    check("to_resume_period", period, 100);

    // ---------------- both gates off after reset ----------------
    do_reset();
    drive(1'b0, 1'b0, TMO);
    check("hz_not_early", mv_count, 0);
    drive(1'b0, 1'b0, 1);
    check("hz_valid", meas_valid, 1);
    check("hz_static", static_code, 2'b11);
    check("hz_period", period, 0);
    check("hz_dead_hl", dead_hl, ALL);
    drive(1'b0, 1'b0, 50);
    check("hz_once", mv_count, 1);
    check("hz_shoot", shoot_through, 0);
    check("hz_deadv", dead_violation, 0);

    // ---------------- asynchronous reset mid-period ----------------
    do_reset();
    pwm_cycle(100, 40, 3, 3);
    pwm_cycle(100, 40, 3, 3);
    drive(1'b1, 1'b0, 20);
    #3;
    reset_n = 1'b0;
    #1;
    check("ar_period", period, 0);
    check("ar_high", high_time, 0);
    check("ar_dead_lh", dead_lh, 0);
    check("ar_static", static_code, 2'b11);
    check("ar_valid", meas_valid, 0);
    pwm_high = 1'b0;
    tick();
    tick();
    reset_n  = 1'b1;
    mv_count = 0;
    pwm_cycle(100, 40, 3, 3);
    check("ar_rearm_nopub", mv_count, 0);
    pwm_cycle(100, 40, 3, 3);
    check("ar_first_pub", mv_at2, 1);
    check("ar_count", mv_count, 1);
    check("ar_pub_period", period, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
